seq_detect_param: RTL and testbench

SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

---
 rtl/seq_detect_param.sv | 149 ++++++++++++++
 tb/tb_seq_detect_param.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_param.sv
// Parameterised serial pattern detector with a programmable pattern and length,
// optional overlapping matches, a saturating match counter and rejection of bad loads.
module seq_detect_param #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             x,
  input  logic             x_valid,
  input  logic             load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic [LEN_W-1:0] len_in,
  input  logic             overlap,
  input  logic             clr_cnt,
  output logic             z,
  output logic [CNT_W-1:0] match_cnt,
  output logic [LEN_W-1:0] fill,
  output logic [1:0]       state,
  output logic             cfg_err
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_FILL   = 2'b01,
    ST_DETECT = 2'b10
  } state_t;

  localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(2);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t             state_r, state_s;
  logic [PAT_W-1:0]   pat_r, pat_s;
  logic [LEN_W-1:0]   len_r, len_s;
  logic [PAT_W-1:0]   hist_r, hist_s;
  logic [LEN_W-1:0]   fill_r, fill_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic               z_r, z_s;
  logic               cfg_err_r, cfg_err_s;

  logic               len_ok_s;
  logic [PAT_W-1:0]   shift_s;
  logic [PAT_W-1:0]   len_mask_s;
  logic [LEN_W-1:0]   fill_inc_s;
  logic               hit_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      sat_inc = v;
    end else begin
      sat_inc = v + CNT_ONE;
    end
  endfunction

  // Next-state, datapath and pulse decode; load outranks any sample in the same cycle.
  always_comb begin
    state_s    = state_r;
    pat_s      = pat_r;
    len_s      = len_r;
    hist_s     = hist_r;
    fill_s     = fill_r;
    cnt_s      = clr_cnt ? {CNT_W{1'b0}} : cnt_r;
    z_s        = 1'b0;
    cfg_err_s  = 1'b0;
    len_ok_s   = (len_in >= LEN_MIN) && (len_in <= LEN_MAX);
    shift_s    = (hist_r << 1'b1) | {{(PAT_W-1){1'b0}}, x};
    fill_inc_s = (fill_r == len_r) ? fill_r : fill_r + LEN_W'(1);
    // A shift by PAT_W wraps to zero, so the mask becomes all ones at full length.
    len_mask_s = (PAT_W'(1) << len_r) - PAT_W'(1);
    hit_s      = (fill_inc_s == len_r) &&
                 (((shift_s ^ pat_r) & len_mask_s) == {PAT_W{1'b0}});

    if (load) begin
      if (len_ok_s) begin
        pat_s   = pat_in;
        len_s   = len_in;
        hist_s  = {PAT_W{1'b0}};
        fill_s  = {LEN_W{1'b0}};
        cnt_s   = {CNT_W{1'b0}};
        state_s = ST_FILL;
      end else begin
        cfg_err_s = 1'b1;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_s = ST_IDLE;
        end
        ST_FILL, ST_DETECT: begin
          if (x_valid) begin
            hist_s  = shift_s;
            fill_s  = fill_inc_s;
            state_s = (fill_inc_s == len_r) ? ST_DETECT : ST_FILL;
            if (hit_s) begin
              z_s   = 1'b1;
              cnt_s = clr_cnt ? CNT_ONE : sat_inc(cnt_r);
              if (!overlap) begin
                fill_s  = {LEN_W{1'b0}};
                state_s = ST_FILL;
              end else begin
                state_s = ST_DETECT;
              end
            end else begin
              z_s = 1'b0;
            end
          end else begin
            hist_s = hist_r;
          end
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      pat_r     <= {PAT_W{1'b0}};
      len_r     <= {LEN_W{1'b0}};
      hist_r    <= {PAT_W{1'b0}};
      fill_r    <= {LEN_W{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      z_r       <= 1'b0;
      cfg_err_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      pat_r     <= pat_s;
      len_r     <= len_s;
      hist_r    <= hist_s;
      fill_r    <= fill_s;
      cnt_r     <= cnt_s;
      z_r       <= z_s;
      cfg_err_r <= cfg_err_s;
    end
  end

  assign z         = z_r;
  assign match_cnt = cnt_r;
  assign fill      = fill_r;
  assign state     = state_r;
  assign cfg_err   = cfg_err_r;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed self-checking bench for seq_detect_param (PAT_W=8, CNT_W=2, LEN_W=4).
module tb_seq_detect_param;

  localparam int PAT_W = 8;
  localparam int CNT_W = 2;
  localparam int LEN_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             x = 1'b0;
  logic             x_valid = 1'b0;
  logic             load = 1'b0;
  logic [PAT_W-1:0] pat_in = '0;
  logic [LEN_W-1:0] len_in = '0;
  logic             overlap = 1'b0;
  logic             clr_cnt = 1'b0;
  logic             z;
  logic [CNT_W-1:0] match_cnt;
  logic [LEN_W-1:0] fill;
  logic [1:0]       state;
  logic             cfg_err;

  int vectors = 0;
  int miscompares = 0;

  seq_detect_param #(.PAT_W(PAT_W), .CNT_W(CNT_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .load(load),
    .pat_in(pat_in), .len_in(len_in), .overlap(overlap), .clr_cnt(clr_cnt),
    .z(z), .match_cnt(match_cnt), .fill(fill), .state(state), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic xb, input logic xv);
    x = xb;
    x_valid = xv;
    @(posedge clk);
    #1;
    x_valid = 1'b0;
    clr_cnt = 1'b0;
  endtask

  task automatic do_load(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] l,
                         input logic ov, input logic xv);
    pat_in = p;
    len_in = l;
    overlap = ov;
    load = 1'b1;
    x = 1'b1;
    x_valid = xv;
    @(posedge clk);
    #1;
    load = 1'b0;
    x_valid = 1'b0;
  endtask

  logic [6:0] bits7;
  logic [6:0] z_ovl;
  logic [6:0] z_novl;

  initial begin
    bits7  = 7'b1101101;  // streamed MSB first: 1,1,0,1,1,0,1
    z_ovl  = 7'b0001001;
    z_novl = 7'b0001000;

    #2;
    check("rst_state", state, 2'b00);
    check("rst_z", z, 1'b0);
    check("rst_cnt", match_cnt, 2'd0);
    check("rst_fill", fill, 4'd0);
    check("rst_cfg_err", cfg_err, 1'b0);
    @(posedge clk); #1; reset = 1'b0;

    // Overlapping detection of 1101
    do_load(8'b0000_1101, 4'd4, 1'b1, 1'b0);
    check("ld_state", state, 2'b01);
    check("ld_fill", fill, 4'd0);
    for (int i = 6; i >= 0; i--) begin
      step(bits7[i], 1'b1);
      check($sformatf("ovl_z%0d", 7 - i), z, z_ovl[i]);
    end
    check("ovl_cnt", match_cnt, 2'd2);
    check("ovl_state", state, 2'b10);
    check("ovl_fill", fill, 4'd4);
    step(1'b0, 1'b0);
    check("z_deassert", z, 1'b0);

    // Non-overlapping detection
    do_load(8'b0000_1101, 4'd4, 1'b0, 1'b0);
    check("reload_cnt", match_cnt, 2'd0);
    for (int i = 6; i >= 0; i--) begin
      step(bits7[i], 1'b1);
      check($sformatf("novl_z%0d", 7 - i), z, z_novl[i]);
    end
    check("novl_cnt", match_cnt, 2'd1);
    check("novl_fill", fill, 4'd3);
    check("novl_state", state, 2'b01);

    // Rejected loads
    do_load(8'hFF, 4'd1, 1'b1, 1'b0);
    check("err1_pulse", cfg_err, 1'b1);
    check("err1_state", state, 2'b01);
    check("err1_cnt", match_cnt, 2'd1);
    step(1'b0, 1'b0);
    check("err1_clear", cfg_err, 1'b0);
    do_load(8'h00, 4'd9, 1'b1, 1'b1);
    check("err2_pulse", cfg_err, 1'b1);
    check("err2_fill", fill, 4'd3);
    check("err2_cnt", match_cnt, 2'd1);
    step(1'b1, 1'b1);
    check("keep_z1", z, 1'b0);
    check("keep_cfg_err", cfg_err, 1'b0);
    step(1'b0, 1'b1);
    check("keep_z2", z, 1'b0);
    step(1'b1, 1'b1);
    check("keep_z3", z, 1'b1);
    check("keep_cnt", match_cnt, 2'd2);

    // Counter saturation and clear-with-match
    do_load(8'b0000_0011, 4'd2, 1'b1, 1'b0);
    step(1'b1, 1'b1);
    check("sat_z1", z, 1'b0);
    for (int i = 2; i <= 7; i++) begin
      step(1'b1, 1'b1);
      check($sformatf("sat_z%0d", i), z, 1'b1);
      check($sformatf("sat_cnt%0d", i), match_cnt, (i - 1 > 3) ? 32'd3 : 32'(i - 1));
    end
    clr_cnt = 1'b1;
    step(1'b1, 1'b1);
    check("clr_hit_cnt", match_cnt, 2'd1);
    clr_cnt = 1'b1;
    step(1'b0, 1'b0);
    check("clr_cnt", match_cnt, 2'd0);

    // Asynchronous reset mid-pattern
    do_load(8'b0000_1101, 4'd4, 1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    check("pre_rst_fill", fill, 4'd3);
    #2 reset = 1'b1;
    #1;
    check("arst_state", state, 2'b00);
    check("arst_fill", fill, 4'd0);
    @(posedge clk); #1; reset = 1'b0;
    step(1'b1, 1'b1);
    check("idle_z", z, 1'b0);
    check("idle_fill", fill, 4'd0);
    check("idle_state", state, 2'b00);

    // Gaps in x_valid and load/x_valid collision
    do_load(8'b0000_0101, 4'd3, 1'b1, 1'b0);
    step(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0);
      check($sformatf("gap_fill%0d", i), fill, 4'd1);
    end
    step(1'b0, 1'b1);
    check("gap_z_mid", z, 1'b0);
    step(1'b1, 1'b1);
    check("gap_z_hit", z, 1'b1);
    check("gap_state", state, 2'b10);
    step(1'b0, 1'b0);
    check("gap_z_drop", z, 1'b0);
    do_load(8'b0000_0101, 4'd3, 1'b1, 1'b1);
    check("coll_fill", fill, 4'd0);
    check("coll_state", state, 2'b01);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    check("coll_no_z", z, 1'b0);
    check("coll_fill2", fill, 4'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
